// File: rtl/find_top_bottom.sv
// -----------------------------------------------------------------------------
// find_top_bottom
//
// First search stage of the star finder. On start it raster-scans the frame
// held in pixel RAM. The first bright pixel sets mostTop and midPix; the block
// then walks down column midPix until it meets a dark row or the frame bottom,
// and the last bright row becomes mostBottom. A one-cycle TopandBottomFound
// pulse then resets and launches the left/right edge finders.
//
// Optional feature (compile-time macro FIND_TB_CENTRE_EN):
//   After the first hit, walk right along row mostTop while pixels are bright.
//   midPix becomes the truncated midpoint of that run, and the downward walk
//   uses that column. Without the macro, midPix is the x of the first hit.
//
// Ports:
//   clk                in   clock, all logic on posedge
//   resetn             in   synchronous active-low reset
//   start              in   begin a search (sampled only in IDLE)
//   mem_addr           out  pixel RAM read address = y*X_RES + x
//   pix_val            in   RAM read data, valid one cycle after mem_addr
//   mostTop            out  first row containing a bright pixel
//   mostBottom         out  last bright row of column midPix, contiguous from mostTop
//   midPix             out  column handed to the left/right stage
//   TopandBottomFound  out  1-cycle pulse, data outputs valid
//   noneFound          out  1-cycle pulse, frame has no bright pixel
//   busy               out  high from start accept through the pulse cycle
// -----------------------------------------------------------------------------
module find_top_bottom #(
  parameter int XSZ       = 6,
  parameter int YSZ       = 6,
  parameter int ADDR_SZ   = 12,
  parameter int COL_SZ    = 3,
  parameter int X_RES     = 60,
  parameter int Y_RES     = 60,
  parameter int THRESHOLD = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output logic [ADDR_SZ-1:0] mem_addr,
  input  logic [COL_SZ-1:0]  pix_val,
  output logic [YSZ-1:0]     mostTop,
  output logic [YSZ-1:0]     mostBottom,
  output logic [XSZ-1:0]     midPix,
  output logic               TopandBottomFound,
  output logic               noneFound,
  output logic               busy
);

  localparam logic [XSZ-1:0]    X_MAX  = XSZ'(X_RES - 1);
  localparam logic [YSZ-1:0]    Y_MAX  = YSZ'(Y_RES - 1);
  localparam logic [COL_SZ-1:0] BLACK  = COL_SZ'(THRESHOLD);
  localparam logic [ADDR_SZ-1:0] STRIDE = ADDR_SZ'(X_RES);

`ifdef FIND_TB_CENTRE_EN
  typedef enum logic [3:0] {
    IDLE, SCAN_F, SCAN_C, RUN_F, RUN_C, DOWN_F, DOWN_C, FOUND, NONE
  } state_t;

  // Truncating midpoint, computed one bit wider so the sum cannot overflow.
  function automatic logic [XSZ-1:0] centre(input logic [XSZ-1:0] a,
                                            input logic [XSZ-1:0] b);
    logic [XSZ:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[XSZ:1];
  endfunction
`else
  typedef enum logic [3:0] {
    IDLE, SCAN_F, SCAN_C, DOWN_F, DOWN_C, FOUND, NONE
  } state_t;
`endif

  state_t         state;
  logic [XSZ-1:0] x;
  logic [YSZ-1:0] y;
  logic           bright;

  assign bright = (pix_val != BLACK);

  // The downward walk reuses x (it is parked on midPix), so one address
  // expression serves every state. It only changes on state transitions out
  // of a CHECK state, so it is stable through each FETCH/CHECK pair.
  assign mem_addr = ADDR_SZ'(y) * STRIDE + ADDR_SZ'(x);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= IDLE;
      x                 <= '0;
      y                 <= '0;
      mostTop           <= '0;
      mostBottom        <= '0;
      midPix            <= '0;
      TopandBottomFound <= 1'b0;
      noneFound         <= 1'b0;
      busy              <= 1'b0;
    end else begin
      TopandBottomFound <= 1'b0;
      noneFound         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            state <= SCAN_F;
          end
        end

        SCAN_F: state <= SCAN_C;

        SCAN_C: begin
          if (bright) begin
            mostTop    <= y;
            mostBottom <= y;
            midPix     <= x;
`ifdef FIND_TB_CENTRE_EN
            if (x == X_MAX) begin
              state <= DOWN_F;
            end else begin
              x     <= x + 1'b1;
              state <= RUN_F;
            end
`else
            state <= DOWN_F;
`endif
          end else if (x != X_MAX) begin
            x     <= x + 1'b1;
            state <= SCAN_F;
          end else if (y != Y_MAX) begin
            x     <= '0;
            y     <= y + 1'b1;
            state <= SCAN_F;
          end else begin
            mostTop    <= '0;
            mostBottom <= '0;
            midPix     <= '0;
            noneFound  <= 1'b1;
            state      <= NONE;
          end
        end

`ifdef FIND_TB_CENTRE_EN
        RUN_F: state <= RUN_C;

        // midPix still holds the first bright x of the run here.
        RUN_C: begin
          if (bright && x != X_MAX) begin
            x     <= x + 1'b1;
            state <= RUN_F;
          end else if (bright) begin
            x      <= centre(midPix, x);
            midPix <= centre(midPix, x);
            state  <= DOWN_F;
          end else begin
            x      <= centre(midPix, x - 1'b1);
            midPix <= centre(midPix, x - 1'b1);
            state  <= DOWN_F;
          end
        end
`endif

        DOWN_F: state <= DOWN_C;

        DOWN_C: begin
          if (bright) begin
            mostBottom <= y;
            if (y == Y_MAX) begin
              TopandBottomFound <= 1'b1;
              state             <= FOUND;
            end else begin
              y     <= y + 1'b1;
              state <= DOWN_F;
            end
          end else begin
            TopandBottomFound <= 1'b1;
            state             <= FOUND;
          end
        end

        FOUND, NONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
